// File: rtl/eater_pkg.sv
// eater_pkg -- shared definitions for the 8-bit breadboard-style CPU
// microsequencer.
//
// Contents:
//   * control-word bit constants (16-bit map, HLT at the MSB, FI at the LSB)
//   * opcode enumeration
//   * flag-bit indices into the registered ALU flag pair
//   * op_length(): number of microsteps an opcode occupies, including fetch
package eater_pkg;

  // Control-word bits, MSB to LSB.
  localparam logic [15:0] HLT = 16'h8000;  // halt clock
  localparam logic [15:0] MI  = 16'h4000;  // memory address register in
  localparam logic [15:0] RI  = 16'h2000;  // RAM in
  localparam logic [15:0] RO  = 16'h1000;  // RAM out
  localparam logic [15:0] IO  = 16'h0800;  // instruction register out
  localparam logic [15:0] II  = 16'h0400;  // instruction register in
  localparam logic [15:0] AI  = 16'h0200;  // A register in
  localparam logic [15:0] AO  = 16'h0100;  // A register out
  localparam logic [15:0] EO  = 16'h0080;  // ALU (sum) out
  localparam logic [15:0] SU  = 16'h0040;  // ALU subtract
  localparam logic [15:0] BI  = 16'h0020;  // B register in
  localparam logic [15:0] OI  = 16'h0010;  // output register in
  localparam logic [15:0] CE  = 16'h0008;  // program counter enable
  localparam logic [15:0] CO  = 16'h0004;  // program counter out
  localparam logic [15:0] J   = 16'h0002;  // jump (program counter in)
  localparam logic [15:0] FI  = 16'h0001;  // flags register in

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Indices into the 2-bit flags input.
  localparam int FLAG_CF = 1;
  localparam int FLAG_ZF = 0;

  // Unclamped instruction length in microsteps (fetch included).
  function automatic int op_length(input logic [3:0] op);
    case (op)
      OP_LDA, OP_STA: op_length = 4;
      OP_ADD, OP_SUB: op_length = 5;
      default:        op_length = 3;
    endcase
  endfunction

endpackage

// File: rtl/control_rom.sv
// control_rom -- combinational microcode ROM.
//
// Maps (step, instruction, flags) to the control word for that step and a
// 'last' flag marking the final microword of the instruction. Also produces
// the following step index so the sequencer needs no length knowledge.
//
// Ports:
//   step        in  STEP_W  microstep index being issued
//   instruction in  OP_W    opcode
//   flags       in  2       {CF, ZF}
//   word        out CW      control word for this step
//   last        out 1       word is the final one of the instruction
//   next_step   out STEP_W  step index to issue on the following edge
module control_rom
  import eater_pkg::*;
#(
  parameter int OP_W      = 4,
  parameter int CW        = 16,
  parameter int STEP_W    = 3,
  parameter int MAX_STEPS = 5
) (
  input  logic [STEP_W-1:0] step,
  input  logic [OP_W-1:0]   instruction,
  input  logic [1:0]        flags,
  output logic [CW-1:0]     word,
  output logic              last,
  output logic [STEP_W-1:0] next_step
);

  logic [3:0]  op4;
  logic        op_known;
  logic [15:0] w16;
  int          len;
  int          s;

  // Opcodes wider than 4 bits with any upper bit set are undefined.
  assign op4      = 4'(instruction);
  assign op_known = (OP_W'(op4) == instruction);

  always_comb begin
    w16       = 16'h0000;
    last      = 1'b0;
    next_step = '0;
    s         = int'(step);

    len = op_known ? op_length(op4) : 3;
    if (len > MAX_STEPS) len = MAX_STEPS;

    if (s >= len) begin
      // Stale step after a mid-instruction opcode change: emit nothing and
      // restart at fetch.
      w16       = 16'h0000;
      last      = 1'b0;
      next_step = '0;
    end else begin
      last      = (s == len - 1);
      next_step = last ? '0 : STEP_W'(s + 1);

      case (s)
        0: w16 = MI | CO;
        1: w16 = RO | II | CE;
        default: begin
          if (op_known) begin
            case (op4)
              OP_LDA: w16 = (s == 2) ? (IO | MI) : (RO | AI);
              OP_ADD: w16 = (s == 2) ? (IO | MI) :
                            (s == 3) ? (RO | BI) : (EO | AI | FI);
              OP_SUB: w16 = (s == 2) ? (IO | MI) :
                            (s == 3) ? (RO | BI) : (EO | AI | SU | FI);
              OP_STA: w16 = (s == 2) ? (IO | MI) : (AO | RI);
              OP_LDI: w16 = IO | AI;
              OP_JMP: w16 = IO | J;
              OP_JC:  w16 = flags[FLAG_CF] ? (IO | J) : 16'h0000;
              OP_JZ:  w16 = flags[FLAG_ZF] ? (IO | J) : 16'h0000;
              OP_OUT: w16 = AO | OI;
              OP_HLT: w16 = HLT;
              default: w16 = 16'h0000;
            endcase
          end
        end
      endcase
    end

    word = CW'(w16);
  end

endmodule

// File: rtl/microsequencer.sv
// microsequencer -- microcode sequencer for the 8-bit breadboard CPU.
//
// Every rising edge (unless halted) registers the control word for the
// current step and advances the step counter. Issuing HLT latches 'halted'
// and freezes the sequencer until reset.
//
// MAX_STEPS must lie in 3 .. 2**STEP_W.
//
// Ports:
//   clk         in  1       clock, rising edge active
//   rst         in  1       asynchronous active-high reset
//   instruction in  OP_W    opcode from the instruction register
//   flags       in  2       registered ALU flags {CF, ZF}
//   ctrl_data   out CW      registered control word
//   step        out STEP_W  microstep index issued on the next edge
//   instr_done  out 1       ctrl_data holds the last word of an instruction
//   halted      out 1       sticky halt status
module microsequencer
  import eater_pkg::*;
#(
  parameter int OP_W      = 4,
  parameter int CW        = 16,
  parameter int STEP_W    = 3,
  parameter int MAX_STEPS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   instruction,
  input  logic [1:0]        flags,
  output logic [CW-1:0]     ctrl_data,
  output logic [STEP_W-1:0] step,
  output logic              instr_done,
  output logic              halted
);

  logic [CW-1:0]     rom_word;
  logic              rom_last;
  logic [STEP_W-1:0] rom_next;
  logic              rom_halt;

  control_rom #(
    .OP_W      (OP_W),
    .CW        (CW),
    .STEP_W    (STEP_W),
    .MAX_STEPS (MAX_STEPS)
  ) u_rom (
    .step        (step),
    .instruction (instruction),
    .flags       (flags),
    .word        (rom_word),
    .last        (rom_last),
    .next_step   (rom_next)
  );

  // HLT occupies the control-word MSB.
  assign rom_halt = rom_word[CW-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_data  <= '0;
      step       <= '0;
      instr_done <= 1'b0;
      halted     <= 1'b0;
    end else if (!halted) begin
      ctrl_data  <= rom_word;
      step       <= rom_next;
      // A halt word never completes: the machine stops on it.
      instr_done <= rom_last & ~rom_halt;
      halted     <= rom_halt;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
module tb_microsequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  instruction = 4'h0;
  logic [1:0]  flags = 2'b00;
  logic [15:0] ctrl_data;
  logic [2:0]  step;
  logic        instr_done;
  logic        halted;

  logic [3:0]  instr4 = 4'h2;
  logic [1:0]  flags4 = 2'b00;
  logic [15:0] ctrl4;
  logic [2:0]  step4;
  logic        done4;
  logic        halt4;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  microsequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .flags       (flags),
    .ctrl_data   (ctrl_data),
    .step        (step),
    .instr_done  (instr_done),
    .halted      (halted)
  );

  microsequencer #(.MAX_STEPS(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .instruction (instr4),
    .flags       (flags4),
    .ctrl_data   (ctrl4),
    .step        (step4),
    .instr_done  (done4),
    .halted      (halt4)
  );

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  fl;
    logic [15:0] ctrl;
    logic [2:0]  stp;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic [3:0] op, input logic [1:0] fl,
                   input logic [15:0] ctrl, input logic [2:0] stp,
                   input logic done);
    vec_t e;
    e.op = op; e.fl = fl; e.ctrl = ctrl; e.stp = stp; e.done = done;
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reset asserted away from the clock edge; outputs must clear at once.
  task automatic do_reset(input string nm);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk({nm, " rst ctrl"}, 32'(ctrl_data), 32'h0);
    chk({nm, " rst step"}, 32'(step), 32'h0);
    chk({nm, " rst done"}, 32'(instr_done), 32'h0);
    chk({nm, " rst halted"}, 32'(halted), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic edge_chk(input string nm, input logic [15:0] ctrl,
                          input logic [2:0] stp, input logic done);
    @(posedge clk);
    #1;
    chk({nm, " ctrl"}, 32'(ctrl_data), 32'(ctrl));
    chk({nm, " step"}, 32'(step), 32'(stp));
    chk({nm, " done"}, 32'(instr_done), 32'(done));
  endtask

  initial begin
    // Back-to-back program, one record per rising edge.
    v(4'h1, 2'b00, 16'h4004, 3'd1, 1'b0);   // LDA
    v(4'h1, 2'b00, 16'h1408, 3'd2, 1'b0);
    v(4'h1, 2'b00, 16'h4800, 3'd3, 1'b0);
    v(4'h1, 2'b00, 16'h1200, 3'd0, 1'b1);
    v(4'h2, 2'b00, 16'h4004, 3'd1, 1'b0);   // ADD
    v(4'h2, 2'b00, 16'h1408, 3'd2, 1'b0);
    v(4'h2, 2'b00, 16'h4800, 3'd3, 1'b0);
    v(4'h2, 2'b00, 16'h1020, 3'd4, 1'b0);
    v(4'h2, 2'b00, 16'h0281, 3'd0, 1'b1);
    v(4'h3, 2'b00, 16'h4004, 3'd1, 1'b0);   // SUB
    v(4'h3, 2'b00, 16'h1408, 3'd2, 1'b0);
    v(4'h3, 2'b00, 16'h4800, 3'd3, 1'b0);
    v(4'h3, 2'b00, 16'h1020, 3'd4, 1'b0);
    v(4'h3, 2'b00, 16'h02C1, 3'd0, 1'b1);
    v(4'h4, 2'b00, 16'h4004, 3'd1, 1'b0);   // STA
    v(4'h4, 2'b00, 16'h1408, 3'd2, 1'b0);
    v(4'h4, 2'b00, 16'h4800, 3'd3, 1'b0);
    v(4'h4, 2'b00, 16'h2100, 3'd0, 1'b1);
    v(4'h5, 2'b00, 16'h4004, 3'd1, 1'b0);   // LDI
    v(4'h5, 2'b00, 16'h1408, 3'd2, 1'b0);
    v(4'h5, 2'b00, 16'h0A00, 3'd0, 1'b1);
    v(4'h6, 2'b00, 16'h4004, 3'd1, 1'b0);   // JMP
    v(4'h6, 2'b00, 16'h1408, 3'd2, 1'b0);
    v(4'h6, 2'b00, 16'h0802, 3'd0, 1'b1);
    v(4'h7, 2'b10, 16'h4004, 3'd1, 1'b0);   // JC taken
    v(4'h7, 2'b10, 16'h1408, 3'd2, 1'b0);
    v(4'h7, 2'b10, 16'h0802, 3'd0, 1'b1);
    v(4'h7, 2'b00, 16'h4004, 3'd1, 1'b0);   // JC not taken
    v(4'h7, 2'b00, 16'h1408, 3'd2, 1'b0);
    v(4'h7, 2'b00, 16'h0000, 3'd0, 1'b1);
    v(4'h7, 2'b10, 16'h4004, 3'd1, 1'b0);   // JC: CF drops at step 2
    v(4'h7, 2'b10, 16'h1408, 3'd2, 1'b0);
    v(4'h7, 2'b00, 16'h0000, 3'd0, 1'b1);
    v(4'h7, 2'b00, 16'h4004, 3'd1, 1'b0);   // JC: CF only at step 2
    v(4'h7, 2'b00, 16'h1408, 3'd2, 1'b0);
    v(4'h7, 2'b10, 16'h0802, 3'd0, 1'b1);
    v(4'h8, 2'b01, 16'h4004, 3'd1, 1'b0);   // JZ taken
    v(4'h8, 2'b01, 16'h1408, 3'd2, 1'b0);
    v(4'h8, 2'b01, 16'h0802, 3'd0, 1'b1);
    v(4'h8, 2'b01, 16'h4004, 3'd1, 1'b0);   // JZ: ZF drops at step 2
    v(4'h8, 2'b01, 16'h1408, 3'd2, 1'b0);
    v(4'h8, 2'b10, 16'h0000, 3'd0, 1'b1);
    v(4'h0, 2'b00, 16'h4004, 3'd1, 1'b0);   // NOP
    v(4'h0, 2'b00, 16'h1408, 3'd2, 1'b0);
    v(4'h0, 2'b00, 16'h0000, 3'd0, 1'b1);
    v(4'hE, 2'b00, 16'h4004, 3'd1, 1'b0);   // OUT
    v(4'hE, 2'b00, 16'h1408, 3'd2, 1'b0);
    v(4'hE, 2'b00, 16'h0110, 3'd0, 1'b1);
    v(4'h9, 2'b11, 16'h4004, 3'd1, 1'b0);   // undefined 1001
    v(4'h9, 2'b11, 16'h1408, 3'd2, 1'b0);
    v(4'h9, 2'b11, 16'h0000, 3'd0, 1'b1);
    v(4'hD, 2'b11, 16'h4004, 3'd1, 1'b0);   // undefined 1101
    v(4'hD, 2'b11, 16'h1408, 3'd2, 1'b0);
    v(4'hD, 2'b11, 16'h0000, 3'd0, 1'b1);
    v(4'h2, 2'b00, 16'h4004, 3'd1, 1'b0);   // ADD -> SUB at step 4
    v(4'h2, 2'b00, 16'h1408, 3'd2, 1'b0);
    v(4'h2, 2'b00, 16'h4800, 3'd3, 1'b0);
    v(4'h2, 2'b00, 16'h1020, 3'd4, 1'b0);
    v(4'h3, 2'b00, 16'h02C1, 3'd0, 1'b1);
    v(4'h2, 2'b00, 16'h4004, 3'd1, 1'b0);   // ADD -> LDI at step 3
    v(4'h2, 2'b00, 16'h1408, 3'd2, 1'b0);
    v(4'h2, 2'b00, 16'h4800, 3'd3, 1'b0);
    v(4'h5, 2'b00, 16'h0000, 3'd0, 1'b0);   // stale step: zero word
    v(4'h1, 2'b00, 16'h4004, 3'd1, 1'b0);   // resumes at fetch
  end

  initial begin
    #1;
    // Clamped-length instance: ADD with MAX_STEPS = 4.
    instruction = 4'h0;
    do_reset("m4");
    begin
      logic [15:0] c4 [5];
      logic [2:0]  s4 [5];
      logic        d4 [5];
      c4[0] = 16'h4004; s4[0] = 3'd1; d4[0] = 1'b0;
      c4[1] = 16'h1408; s4[1] = 3'd2; d4[1] = 1'b0;
      c4[2] = 16'h4800; s4[2] = 3'd3; d4[2] = 1'b0;
      c4[3] = 16'h1020; s4[3] = 3'd0; d4[3] = 1'b1;
      c4[4] = 16'h4004; s4[4] = 3'd1; d4[4] = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        chk($sformatf("m4 e%0d ctrl", k), 32'(ctrl4), 32'(c4[k]));
        chk($sformatf("m4 e%0d step", k), 32'(step4), 32'(s4[k]));
        chk($sformatf("m4 e%0d done", k), 32'(done4), 32'(d4[k]));
      end
    end

    // Table-driven program.
    instruction = tbl[0].op;
    flags       = tbl[0].fl;
    do_reset("tbl");
    for (int i = 0; i < tbl.size(); i++) begin
      instruction = tbl[i].op;
      flags       = tbl[i].fl;
      edge_chk($sformatf("v%0d", i), tbl[i].ctrl, tbl[i].stp, tbl[i].done);
      chk($sformatf("v%0d halted", i), 32'(halted), 32'h0);
    end

    // HLT: halts on the third word and stays frozen.
    instruction = 4'hF;
    flags       = 2'b00;
    do_reset("hlt");
    edge_chk("hlt e0", 16'h4004, 3'd1, 1'b0);
    edge_chk("hlt e1", 16'h1408, 3'd2, 1'b0);
    edge_chk("hlt e2", 16'h8000, 3'd0, 1'b0);
    chk("hlt e2 halted", 32'(halted), 32'h1);
    instruction = 4'h1;
    flags       = 2'b11;
    for (int k = 0; k < 10; k++) begin
      edge_chk($sformatf("hold%0d", k), 16'h8000, 3'd0, 1'b0);
      chk($sformatf("hold%0d halted", k), 32'(halted), 32'h1);
    end
    do_reset("unhalt");
    edge_chk("unhalt e0", 16'h4004, 3'd1, 1'b0);
    chk("unhalt halted", 32'(halted), 32'h0);

    // Reset pulsed between edges during ADD.
    instruction = 4'h2;
    do_reset("add");
    edge_chk("add e0", 16'h4004, 3'd1, 1'b0);
    edge_chk("add e1", 16'h1408, 3'd2, 1'b0);
    edge_chk("add e2", 16'h4800, 3'd3, 1'b0);
    edge_chk("add e3", 16'h1020, 3'd4, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst ctrl", 32'(ctrl_data), 32'h0);
    chk("midrst step", 32'(step), 32'h0);
    chk("midrst done", 32'(instr_done), 32'h0);
    #1 rst = 1'b0;
    edge_chk("midrst e0", 16'h4004, 3'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
